// File: rtl/timer_cnt_ctrl_if.sv
// Signal bundle between the register file side and the timer count controller.
// valid/ready does not apply here: every signal is a level sampled at each clk edge, with int_st_clr being a one-cycle strobe.
interface timer_cnt_ctrl_if;
  logic       timer_en;
  logic       div_en;
  logic [3:0] div_val;
  logic       halt_req;
  logic       dbg_mode;
  logic       halt_ack;
  logic       cmp_match;
  logic       int_en;
  logic       int_st_clr;
  logic       cnt_en;
  logic       int_st;
  logic       tim_int;
  logic       dbg_state;

  modport master (
    output timer_en, div_en, div_val, halt_req, dbg_mode, cmp_match, int_en, int_st_clr,
    input  halt_ack, cnt_en, int_st, tim_int, dbg_state
  );

  modport slave (
    input  timer_en, div_en, div_val, halt_req, dbg_mode, cmp_match, int_en, int_st_clr,
    output halt_ack, cnt_en, int_st, tim_int, dbg_state
  );
endinterface

// File: rtl/timer_cnt_ctrl.sv
// Timer counter control: power-of-two prescaled count enable, debug halt handshake,
// and sticky compare-match interrupt status with a masked interrupt line.
module timer_cnt_ctrl #(
  parameter int DIV_W = 8
) (
  input logic              clk,
  input logic              rst,
  timer_cnt_ctrl_if.slave  bus
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_e;

  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
  localparam logic [3:0]       DIV_MAX = 4'(DIV_W);

  state_e           state_q, state_d;
  logic             halt_ack_q, halt_ack_d;
  logic             cnt_en_q, cnt_en_d;
  logic             int_st_q, int_st_d;
  logic             cmp_match_dly_q, cmp_match_dly_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [3:0]       div_val_q, div_val_d;
  logic             div_en_q, div_en_d;

  logic [3:0]       div_val_sat;
  logic [DIV_W-1:0] div_term;
  logic             rise;

  always_comb begin
    state_d = state_q;
    if (state_q == RUN) begin
      if (bus.halt_req && bus.dbg_mode) state_d = HALT;
    end else begin
      if (!bus.halt_req) state_d = RUN;
    end
    halt_ack_d = (state_d == HALT);

    div_val_sat = (bus.div_val > DIV_MAX) ? DIV_MAX : bus.div_val;
    div_val_d   = div_val_sat;
    div_en_d    = bus.div_en;
    // At div_val_q == DIV_W the shifted one falls off and the subtraction wraps to all ones.
    div_term    = (ONE << div_val_q) - ONE;

    div_cnt_d = div_cnt_q;
    cnt_en_d  = 1'b0;
    if (!bus.timer_en) begin
      div_cnt_d = '0;
    end else if (state_d == HALT) begin
      div_cnt_d = div_cnt_q;
    end else if ((div_val_sat != div_val_q) || (bus.div_en != div_en_q)) begin
      div_cnt_d = '0;
    end else if (!bus.div_en) begin
      div_cnt_d = '0;
      cnt_en_d  = 1'b1;
    end else if (div_cnt_q == div_term) begin
      div_cnt_d = '0;
      cnt_en_d  = 1'b1;
    end else begin
      div_cnt_d = div_cnt_q + ONE;
    end

    cmp_match_dly_d = bus.cmp_match;
    rise            = bus.cmp_match && !cmp_match_dly_q && bus.timer_en;
    // A new match edge takes priority over a clear strobe in the same cycle.
    int_st_d = int_st_q;
    if (bus.int_st_clr) int_st_d = 1'b0;
    if (rise)           int_st_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= RUN;
      halt_ack_q      <= 1'b0;
      cnt_en_q        <= 1'b0;
      int_st_q        <= 1'b0;
      cmp_match_dly_q <= 1'b0;
      div_cnt_q       <= '0;
      div_val_q       <= '0;
      div_en_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      halt_ack_q      <= halt_ack_d;
      cnt_en_q        <= cnt_en_d;
      int_st_q        <= int_st_d;
      cmp_match_dly_q <= cmp_match_dly_d;
      div_cnt_q       <= div_cnt_d;
      div_val_q       <= div_val_d;
      div_en_q        <= div_en_d;
    end
  end

  assign bus.halt_ack  = halt_ack_q;
  assign bus.cnt_en    = cnt_en_q;
  assign bus.int_st    = int_st_q;
  assign bus.tim_int   = int_st_q & bus.int_en;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_timer_cnt_ctrl.sv
// Bench for timer_cnt_ctrl: directed vectors, a cycle model of the control rules,
// and literal expectations at the key points of each scenario.
module tb_timer_cnt_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  timer_cnt_ctrl_if bus ();
  timer_cnt_ctrl #(.DIV_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs are changed 2 time units after the active edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Model: prescaler tracked as edges elapsed since the last restart.
  bit m_halt, m_cnt_en, m_int_st, m_prev_match, m_prev_den;
  int m_prev_n, m_ticks;

  always @(posedge clk) begin
    int  n;
    bit  rise;
    n = (bus.div_val > 4'd8) ? 8 : int'(bus.div_val);
    if (rst) begin
      m_halt = 0; m_cnt_en = 0; m_int_st = 0; m_prev_match = 0;
      m_prev_den = 0; m_prev_n = 0; m_ticks = 0;
    end else begin
      m_halt = m_halt ? bus.halt_req : (bus.halt_req && bus.dbg_mode);
      if (!bus.timer_en) begin
        m_ticks = 0; m_cnt_en = 0;
      end else if (m_halt) begin
        m_cnt_en = 0;
      end else if (n != m_prev_n || bus.div_en != m_prev_den) begin
        m_ticks = 0; m_cnt_en = 0;
      end else if (!bus.div_en) begin
        m_ticks = 0; m_cnt_en = 1;
      end else begin
        m_cnt_en = ((m_ticks + 1) % (1 << n)) == 0;
        m_ticks++;
      end
      rise = bus.cmp_match && !m_prev_match && bus.timer_en;
      if (rise) m_int_st = 1;
      else if (bus.int_st_clr) m_int_st = 0;
      m_prev_match = bus.cmp_match;
      m_prev_n     = n;
      m_prev_den   = bus.div_en;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_cnt_en",   bus.cnt_en,    m_cnt_en);
      check("model_halt_ack", bus.halt_ack,  m_halt);
      check("model_state",    bus.dbg_state, m_halt);
      check("model_int_st",   bus.int_st,    m_int_st);
      check("model_tim_int",  bus.tim_int,   m_int_st & bus.int_en);
    end
  end

  task automatic zero_inputs();
    bus.timer_en = 0; bus.div_en = 0; bus.div_val = 0; bus.halt_req = 0;
    bus.dbg_mode = 0; bus.cmp_match = 0; bus.int_en = 0; bus.int_st_clr = 0;
  endtask

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  initial begin
    int first;
    // 1: reset with every input high
    rst = 1;
    bus.timer_en = 1; bus.div_en = 1; bus.div_val = 4'hf; bus.halt_req = 1;
    bus.dbg_mode = 1; bus.cmp_match = 1; bus.int_en = 1; bus.int_st_clr = 1;
    tick();
    chk_en = 1;
    tick();
    check("rst_cnt_en", bus.cnt_en, 0);
    check("rst_halt_ack", bus.halt_ack, 0);
    check("rst_int_st", bus.int_st, 0);
    check("rst_tim_int", bus.tim_int, 0);
    rst = 0;
    zero_inputs();
    tick();

    // 2: divide by 8, then switch to divide by 2 mid-run
    bus.div_en = 1; bus.div_val = 3;
    tick();
    bus.timer_en = 1;
    exp_q = '{8'd8, 8'd16, 8'd19, 8'd21, 8'd23};
    for (int t = 1; t <= 24; t++) begin
      tick();
      if (bus.cnt_en) got_q.push_back(8'(t));
      if (t == 16) bus.div_val = 1;
    end
    check("div_pulse_count", got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0)
      check("div_pulse_cycle", got_q.pop_front(), exp_q.pop_front());

    // 3: halt handshake, honoured only with dbg_mode
    for (int p = 0; p < 2; p++) begin
      bit dbg;
      dbg = (p == 0);
      bus.timer_en = 0; bus.div_en = 0; bus.div_val = 0; bus.halt_req = 0;
      tick();
      bus.dbg_mode = dbg; bus.timer_en = 1;
      for (int t = 1; t <= 30; t++) begin
        bit ack;
        tick();
        ack = dbg && t >= 11 && t <= 20;
        check("halt_ack_cycle", bus.halt_ack, ack);
        check("halt_cnt_en_cycle", bus.cnt_en, !ack);
        if (t == 10) bus.halt_req = 1;
        if (t == 20) bus.halt_req = 0;
      end
    end
    bus.halt_req = 0; bus.dbg_mode = 0;

    // 4: sticky status, single set per held level
    bus.int_en = 1; bus.cmp_match = 0;
    tick();
    bus.cmp_match = 1;
    tick();
    check("irq_set_int_st", bus.int_st, 1);
    check("irq_set_tim_int", bus.tim_int, 1);
    tick();
    bus.int_st_clr = 1;
    tick();
    bus.int_st_clr = 0;
    check("irq_clr_int_st", bus.int_st, 0);
    check("irq_clr_tim_int", bus.tim_int, 0);
    tick();
    tick();
    check("irq_held_no_reset", bus.int_st, 0);
    bus.cmp_match = 0;
    tick();

    // 5: set beats clear; disabled timer ignores edges; mask only gates tim_int
    bus.cmp_match = 1; bus.int_st_clr = 1;
    tick();
    check("irq_set_wins", bus.int_st, 1);
    bus.cmp_match = 0;
    tick();
    bus.int_st_clr = 0;
    check("irq_clr_again", bus.int_st, 0);
    bus.timer_en = 0; bus.cmp_match = 1;
    tick();
    check("irq_timer_off", bus.int_st, 0);
    bus.cmp_match = 0;
    tick();
    bus.timer_en = 1; bus.int_en = 0; bus.cmp_match = 1;
    tick();
    check("irq_masked_st", bus.int_st, 1);
    check("irq_masked_tim_int", bus.tim_int, 0);
    bus.cmp_match = 0;

    // 6: reset while halted with status set and the prescaler part way
    bus.timer_en = 0; bus.div_en = 1; bus.div_val = 3;
    tick();
    bus.timer_en = 1;
    repeat (5) tick();
    bus.halt_req = 1; bus.dbg_mode = 1;
    tick();
    check("pre_rst_halt_ack", bus.halt_ack, 1);
    check("pre_rst_int_st", bus.int_st, 1);
    rst = 1;
    tick();
    check("mid_rst_state", bus.dbg_state, 0);
    check("mid_rst_halt_ack", bus.halt_ack, 0);
    check("mid_rst_int_st", bus.int_st, 0);
    check("mid_rst_cnt_en", bus.cnt_en, 0);
    rst = 0; bus.halt_req = 0;
    first = 0;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (bus.cnt_en && first == 0) first = t;
    end
    check("post_rst_first_pulse", first, 9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
